// File: rtl/bit_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_reader_if
// Description : Byte-stream and peek-window bundle between the input byte
//               source / variable-length decoder (master) and bit_reader
//               (slave).
//               Stream : din, din_vld -> ; <- din_rdy
//               Window : <- win, win_vld, avail
//               Consume: skip_len, skip_vld, flush ->
//               Marker : <- marker_hit, marker_code
// Revision    : 1.0  initial release
// ============================================================================
interface bit_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_WIDTH  = 16,
  parameter int AVAIL_W    = 6
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_vld;
  logic                  din_rdy;
  logic [WIN_WIDTH-1:0]  win;
  logic                  win_vld;
  logic [AVAIL_W-1:0]    avail;
  logic [4:0]            skip_len;
  logic                  skip_vld;
  logic                  flush;
  logic                  marker_hit;
  logic [DATA_WIDTH-1:0] marker_code;

  modport master (
    output din, din_vld, skip_len, skip_vld, flush,
    input  din_rdy, win, win_vld, avail, marker_hit, marker_code
  );

  modport slave (
    input  din, din_vld, skip_len, skip_vld, flush,
    output din_rdy, win, win_vld, avail, marker_hit, marker_code
  );
endinterface
`default_nettype wire

// File: rtl/bit_reader.sv
`default_nettype none
// ============================================================================
// Module      : bit_reader
// Description : MSB-first bit reader. Accepts bytes over a valid/ready
//               handshake into a 32-bit MSB-aligned buffer and presents the
//               oldest 16 bits as a peek window. The consumer drops 0..16
//               bits per cycle (skip) or byte-aligns (flush).
//               Optional feature macro: BIT_READER_UNSTUFF_EN -- removes
//               0xFF00 stuffing, swallows 0xFF fill bytes and detects
//               0xFFxx markers (stalls input until flush).
// Ports       : clk, rst (sync, active high)
//               bus  : bit_reader_if.slave (stream in, window out,
//                      skip/flush in, marker out)
// Revision    : 1.0  initial release
// ============================================================================
module bit_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_WIDTH  = 32,
  parameter int WIN_WIDTH  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  bit_reader_if.slave bus
);

  localparam logic [5:0] c_WIN_BITS  = 6'(WIN_WIDTH);
  localparam logic [5:0] c_FILL_LIM  = 6'(BUF_WIDTH - DATA_WIDTH);
  localparam logic [4:0] c_SKIP_MAX  = 5'(WIN_WIDTH);

  logic [BUF_WIDTH-1:0]  r_buf;
  logic [5:0]            r_avail;

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_ins;
  logic [DATA_WIDTH-1:0] w_ins_byte;
  logic [4:0]            w_skip_sat;
  logic [4:0]            w_skip_eff;
  logic [5:0]            w_avail_post;
  logic [BUF_WIDTH-1:0]  w_shifted;
  logic [BUF_WIDTH-1:0]  w_ins_word;
  logic [2:0]            w_rem;

  // Ready looks only at the registered count: a skip this cycle cannot
  // create room for a byte in the same cycle.
  assign bus.din_rdy = !rst && !bus.flush && !w_stall && (r_avail <= c_FILL_LIM);
  assign w_accept    = bus.din_vld && bus.din_rdy;

  assign bus.win     = r_buf[BUF_WIDTH-1 -: WIN_WIDTH];
  assign bus.win_vld = (r_avail >= c_WIN_BITS);
  assign bus.avail   = r_avail;

  assign w_skip_sat   = (bus.skip_len > c_SKIP_MAX) ? c_SKIP_MAX : bus.skip_len;
  assign w_skip_eff   = (bus.skip_vld && bus.win_vld && !bus.flush) ? w_skip_sat : 5'd0;
  assign w_avail_post = r_avail - {1'b0, w_skip_eff};
  assign w_shifted    = r_buf << w_skip_eff;
  // Bits below the valid region are always zero (only zeros are shifted
  // in), so the new byte can simply be OR-ed in behind the survivors.
  assign w_ins_word   = {w_ins_byte, {(BUF_WIDTH-DATA_WIDTH){1'b0}}} >> w_avail_post;
  // Tail is byte-aligned, so the low three bits are the partial-byte residue.
  assign w_rem        = r_avail[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_avail <= '0;
    end else if (bus.flush) begin
      r_buf   <= r_buf << w_rem;
      r_avail <= r_avail - {3'b000, w_rem};
    end else begin
      r_buf   <= w_shifted | (w_ins ? w_ins_word : '0);
      r_avail <= w_avail_post + (w_ins ? 6'd8 : 6'd0);
    end
  end

`ifdef BIT_READER_UNSTUFF_EN
  logic                  r_pend;
  logic                  r_stall;
  logic                  r_marker_hit;
  logic [DATA_WIDTH-1:0] r_marker_code;
  logic                  w_marker;
  logic                  w_pend_next;

  // A held 0xFF is resolved by the byte that follows it: 00 restores the
  // 0xFF, another FF is fill (stay pending), anything else is a marker.
  always_comb begin
    w_ins       = 1'b0;
    w_ins_byte  = bus.din;
    w_marker    = 1'b0;
    w_pend_next = r_pend;
    if (w_accept) begin
      if (r_pend) begin
        if (bus.din == 8'h00) begin
          w_ins       = 1'b1;
          w_ins_byte  = 8'hFF;
          w_pend_next = 1'b0;
        end else if (bus.din != 8'hFF) begin
          w_marker    = 1'b1;
          w_pend_next = 1'b0;
        end
      end else if (bus.din == 8'hFF) begin
        w_pend_next = 1'b1;
      end else begin
        w_ins = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend        <= 1'b0;
      r_stall       <= 1'b0;
      r_marker_hit  <= 1'b0;
      r_marker_code <= '0;
    end else if (bus.flush) begin
      r_pend       <= 1'b0;
      r_stall      <= 1'b0;
      r_marker_hit <= 1'b0;
    end else begin
      r_pend       <= w_pend_next;
      r_marker_hit <= w_marker;
      if (w_marker) begin
        r_stall       <= 1'b1;
        r_marker_code <= bus.din;
      end
    end
  end

  assign w_stall         = r_stall;
  assign bus.marker_hit  = r_marker_hit;
  assign bus.marker_code = r_marker_code;
`else
  assign w_ins           = w_accept;
  assign w_ins_byte      = bus.din;
  assign w_stall         = 1'b0;
  assign bus.marker_hit  = 1'b0;
  assign bus.marker_code = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_reader
// Description : Self-checking bench for bit_reader. Directed steps followed
//               by random traffic; expectations come from a bit-queue model
//               (front = oldest bit). Honours BIT_READER_UNSTUFF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bit_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_reader_if bif ();

  bit_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int n_err    = 0;
  int n_checks = 0;

  // Reference model state
  bit       q[$];
  bit       m_stall;
  bit       m_pend;
  bit       m_mhit;
  bit [7:0] m_mcode;
  logic     obs_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_win();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < q.size()) w[15-i] = q[i];
    return w;
  endfunction

  task automatic push_byte(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":win"},         bif.win,         model_win());
    chk({tag, ":avail"},       bif.avail,       q.size());
    chk({tag, ":win_vld"},     bif.win_vld,     q.size() >= 16);
    chk({tag, ":marker_hit"},  bif.marker_hit,  m_mhit);
    chk({tag, ":marker_code"}, bif.marker_code, m_mcode);
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, clock,
  // then check the registered outputs at the next negedge.
  task automatic step(input bit vld, input bit [7:0] b, input bit skv,
                      input bit [4:0] skl, input bit fl);
    bit exp_rdy;
    int n;
    bif.din_vld  = vld;
    bif.din      = b;
    bif.skip_vld = skv;
    bif.skip_len = skl;
    bif.flush    = fl;
    #1;
    exp_rdy = !m_stall && !fl && (q.size() <= 24);
    obs_rdy = bif.din_rdy;
    chk("din_rdy", obs_rdy, exp_rdy);
    m_mhit = 1'b0;
    if (fl) begin
      n = q.size() % 8;
      repeat (n) void'(q.pop_front());
      m_stall = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (skv && q.size() >= 16) begin
        n = (skl > 16) ? 16 : int'(skl);
        repeat (n) void'(q.pop_front());
      end
      if (vld && exp_rdy) begin
`ifdef BIT_READER_UNSTUFF_EN
        if (m_pend) begin
          if (b == 8'h00) begin
            push_byte(8'hFF);
            m_pend = 1'b0;
          end else if (b != 8'hFF) begin
            m_pend  = 1'b0;
            m_stall = 1'b1;
            m_mcode = b;
            m_mhit  = 1'b1;
          end
        end else if (b == 8'hFF) begin
          m_pend = 1'b1;
        end else begin
          push_byte(b);
        end
`else
        push_byte(b);
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("step");
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bif.din_vld  = 1'b0;
    bif.din      = 8'h00;
    bif.skip_vld = 1'b0;
    bif.skip_len = 5'd0;
    bif.flush    = 1'b0;
    #1;
    chk("rst:din_rdy", bif.din_rdy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    q.delete();
    m_stall = 1'b0;
    m_pend  = 1'b0;
    m_mhit  = 1'b0;
    m_mcode = 8'h00;
    check_outputs("rst");
    rst = 1'b0;
  endtask

  initial begin
    bit [7:0] rb;
    @(negedge clk);
    do_reset();

    // Two bytes become a full window one cycle later
    step(1, 8'hA5, 0, 0, 0);
    step(1, 8'hC3, 0, 0, 0);
    chk("ab:win", bif.win, 16'hA5C3);
    chk("ab:avail", bif.avail, 16);
    chk("ab:win_vld", bif.win_vld, 1'b1);
    step(1, 8'h7E, 0, 0, 0);
    step(0, 8'h00, 1, 5'd3, 0);
    chk("skip3:win", bif.win, 16'h2E1B);
    chk("skip3:avail", bif.avail, 21);
    // Flush wins over a simultaneous skip
    step(0, 8'h00, 1, 5'd4, 1);
    chk("flush:win", bif.win, 16'hC37E);
    chk("flush:avail", bif.avail, 16);

    // Fill to 32, then skip 8 reopens ready on the following cycle
    do_reset();
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    step(1, 8'h04, 0, 0, 0);
    chk("full:avail", bif.avail, 32);
    step(1, 8'h55, 1, 5'd8, 0);
    chk("full:rdy", obs_rdy, 1'b0);
    chk("skip8:avail", bif.avail, 24);
    step(0, 8'h00, 0, 0, 0);
    chk("skip8:rdy", obs_rdy, 1'b1);
    // Oversized skip saturates at 16
    step(0, 8'h00, 1, 5'd31, 0);
    chk("sat:avail", bif.avail, 8);

`ifdef BIT_READER_UNSTUFF_EN
    do_reset();
    step(1, 8'hFF, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    chk("stuff:avail", bif.avail, 16);
    chk("stuff:win", bif.win, 16'hFF12);
    step(1, 8'hFF, 0, 0, 0);
    step(1, 8'hD9, 0, 0, 0);
    chk("mk:hit", bif.marker_hit, 1'b1);
    chk("mk:code", bif.marker_code, 8'hD9);
    step(1, 8'h33, 1, 5'd4, 0);
    chk("mk:rdy", obs_rdy, 1'b0);
    chk("mk:hit_once", bif.marker_hit, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h33, 0, 0, 0);
    chk("mk:rdy_after_flush", obs_rdy, 1'b1);
`endif

    // Reset mid-operation discards buffered bits and a held 0xFF
    do_reset();
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    do_reset();
    chk("rst2:avail", bif.avail, 0);
    chk("rst2:win_vld", bif.win_vld, 1'b0);
    step(1, 8'h00, 0, 0, 0);
    chk("rst2:avail8", bif.avail, 8);
    chk("rst2:win", bif.win, 16'h0000);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = 8'hFF;
        1:       rb = 8'h00;
        default: rb = 8'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, rb, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 20)), $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_reader.md
# bit_reader

Entropy-decode front end: consumes the byte stream drained from the input `basic_fifo` over a valid/ready handshake and presents an MSB-first 16-bit peek window to the variable-length decoder. The decoder consumes 0..16 bits per cycle. This is the reading counterpart of the encoder-side bit packer. It keeps a 32-bit bit buffer, supports byte-aligning flush, and optionally removes JPEG-style 0xFF00 stuffing and detects markers.

## Interface
- `DATA_WIDTH`, 8, input byte width; only 8 is supported.
- `BUF_WIDTH`, 32, bit buffer depth in bits.
- `WIN_WIDTH`, 16, peek window width; also the maximum skip.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  8  stream byte.
- `din_vld`  in  1  byte valid.
- `din_rdy`  out  1  byte accepted when `din_vld & din_rdy`.
- `win`  out  16  next 16 unconsumed bits, MSB = oldest bit.
- `win_vld`  out  1  at least 16 bits buffered.
- `avail`  out  6  buffered bit count, 0..32.
- `skip_len`  in  5  bits to consume, 0..16; values above 16 saturate to 16.
- `skip_vld`  in  1  consume request; takes effect only when `win_vld` = 1.
- `flush`  in  1  one-cycle pulse: discard `avail % 8` bits (byte align).
- `marker_hit`  out  1  one-cycle pulse on marker detection.
- `marker_code`  out  8  second byte of the last detected marker.

## Operation
- Buffer is MSB-aligned. Valid bits occupy `buf[31 -: avail]`. `win = buf[31:16]`. `win_vld = (avail >= 16)`.
- Skip: `buf <<= skip_len`, `avail -= skip_len`. Ignored when `win_vld` = 0.
- Fill: an accepted byte is written at bit offset `avail - skip_eff` from the MSB, where `skip_eff` is the skip applied that same cycle. `avail += 8`.
- `din_rdy = !rst & !flush & !stall & (avail <= 24)`. The compare uses registered `avail`, not post-skip `avail`.
- Simultaneous skip and fill in one cycle: `avail_next = avail - skip_eff + 8`. No bit is lost or duplicated.
- The buffer tail is always byte-aligned, so `avail % 8` is the remainder of the partially consumed byte.
- Flush: `buf <<= avail % 8`, `avail -= avail % 8`. Flush clears `stall` and the pending 0xFF flag. A skip in the same cycle is ignored, because flush has priority.
- Arithmetic: `avail` is 6 bits unsigned and never exceeds 32 or goes below 0 by construction.

## Timing
- Reset values: `avail`=0, `buf`=0, `win`=0, `win_vld`=0, `din_rdy`=0 while `rst`=1, `marker_hit`=0, `marker_code`=0, `stall`=0, pending flag=0.
- A byte accepted in cycle N is visible in `win` and `avail` in cycle N+1.
- A skip issued in cycle N updates `win` in cycle N+1. Back-to-back skips every cycle are legal.
- `din_rdy` rises in the cycle after `avail` drops to 24 or below.
- Reset asserted mid-operation discards all buffered bits and the pending state on the next edge.

## Configuration
- Macro: `BIT_READER_UNSTUFF_EN`.
- When the macro is defined:
  - An accepted 0xFF is held in the pending flag and not inserted.
  - If the next accepted byte is 0x00, insert 0xFF and drop the 0x00.
  - If the next accepted byte is 0xFF, insert nothing and keep the pending flag set. This is fill-byte behaviour.
  - Any other byte X is a marker: drop both bytes, set `marker_code`=X, pulse `marker_hit` in the following cycle, and set `stall`.
  - `din_rdy` stays 0 until `flush`. Buffered bits remain consumable.
  - The `avail <= 24` check reserves space for the held byte, so insertion never overflows.
- Without the macro: every byte is inserted verbatim. `marker_hit` and `marker_code` are tied to 0, `stall` is always 0, and there is no pending logic.

## Test plan
- Reset, then accept 0xA5, 0xC3 → next cycle `win`=0xA5C3, `win_vld`=1, `avail`=16.
- With A5 C3 7E buffered, skip 3 → `win`=0x2E1B, `avail`=21.
- Accept 4 bytes with no skip → `avail`=32, `din_rdy`=0. Skip 8 → `avail`=24, and `din_rdy`=1 in the next cycle.
- With `avail`=21 after skip 3, pulse `flush` → `avail`=16, `win`=0xC37E. A skip asserted in the flush cycle is ignored.
- Unstuffing (macro on):
  - Feed FF 00 12 → `avail`=16, `win`=0xFF12.
  - Then feed FF D9 → `marker_hit` pulses once, `marker_code`=0xD9, `din_rdy` stays 0 until `flush`.
- Assert `rst` with `avail`=24 and 0xFF pending → next cycle `avail`=0, `win_vld`=0. Feeding 0x00 then inserts 0x00.
